// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP adder types, exception codes and widths
package fpu_pkg;

  localparam int MANT_W = 25;

  typedef enum logic [1:0] {IDLE, ADD, ACK, WAIT_REL} mant_add_state_t;

  localparam logic [1:0] ADD_EXC_OP1_NEG = 2'b01;
  localparam logic [1:0] ADD_EXC_PROTO   = 2'b10;

endpackage

// File: rtl/fpu_digit_add.sv
// rtl/fpu_digit_add.sv - combinational DIGIT-bit adder slice with carry in/out
module fpu_digit_add #(
  parameter int DIGIT = 5
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/fpu_mant_adder.sv
// rtl/fpu_mant_adder.sv - digit-serial mantissa adder behind the FP adder valid/ack port
module fpu_mant_adder
  import fpu_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int DIGIT = 5
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Adder_valid,
  input  logic [WIDTH-1:0] Adder_datain1,
  input  logic [WIDTH-1:0] Adder_datain2,
  output logic [WIDTH-1:0] Adder_dataout,
  output logic             Adder_carryout,
  output logic [1:0]       Adder_Exc,
  output logic             Adder_ack
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  mant_add_state_t  state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, neg_q, neg_d, proto_q, proto_d;
  logic             carryout_q, carryout_d, ack_q, ack_d;
  logic [1:0]       exc_q, exc_d;
  logic             proto_n;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout;

  assign dig_a = op1_q[int'(cnt_q)*DIGIT +: DIGIT];
  assign dig_b = op2_q[int'(cnt_q)*DIGIT +: DIGIT];

  fpu_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    neg_d      = neg_q;
    proto_d    = proto_q;
    dataout_d  = dataout_q;
    carryout_d = carryout_q;
    exc_d      = exc_q;
    ack_d      = 1'b0;
    proto_n    = proto_q;
    case (state_q)
      IDLE: begin
        if (Adder_valid) begin
          op1_d   = Adder_datain1;
          op2_d   = Adder_datain2;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          neg_d   = Adder_datain1[WIDTH-1];
          proto_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (!Adder_valid) begin
          state_d = IDLE;
        end else begin
          // operand drift is only flagged; the sum always uses the latched copies
          proto_n = proto_q | (Adder_datain1 != op1_q) | (Adder_datain2 != op2_q);
          proto_d = proto_n;
          sum_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_sum;
          carry_d = dig_cout;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            dataout_d  = sum_d;
            carryout_d = dig_cout;
            exc_d      = (neg_q ? ADD_EXC_OP1_NEG : 2'b00) | (proto_n ? ADD_EXC_PROTO : 2'b00);
            ack_d      = 1'b1;
            cnt_d      = '0;
            state_d    = ACK;
          end
        end
      end
      ACK: begin
        state_d = Adder_valid ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (!Adder_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      neg_q      <= 1'b0;
      proto_q    <= 1'b0;
      dataout_q  <= '0;
      carryout_q <= 1'b0;
      exc_q      <= 2'b00;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      neg_q      <= neg_d;
      proto_q    <= proto_d;
      dataout_q  <= dataout_d;
      carryout_q <= carryout_d;
      exc_q      <= exc_d;
      ack_q      <= ack_d;
    end
  end

  assign Adder_dataout  = dataout_q;
  assign Adder_carryout = carryout_q;
  assign Adder_Exc      = exc_q;
  assign Adder_ack      = ack_q;

endmodule

// File: tb/tb_fpu_mant_adder.sv
// tb/tb_fpu_mant_adder.sv - directed and random checks of fpu_mant_adder against d1+d2
module tb_fpu_mant_adder;

  localparam int W   = 25;
  localparam int LAT = 6;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         Adder_valid;
  logic [W-1:0] Adder_datain1, Adder_datain2;
  logic [W-1:0] Adder_dataout;
  logic         Adder_carryout;
  logic [1:0]   Adder_Exc;
  logic         Adder_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] last_sum;
  logic         last_carry;
  logic [1:0]   last_exc;

  fpu_mant_adder dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .Adder_valid    (Adder_valid),
    .Adder_datain1  (Adder_datain1),
    .Adder_datain2  (Adder_datain2),
    .Adder_dataout  (Adder_dataout),
    .Adder_carryout (Adder_carryout),
    .Adder_Exc      (Adder_Exc),
    .Adder_ack      (Adder_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: chg_cycle in 1..5 perturbs an operand mid-operation (0 = none),
  // hold = extra cycles valid stays high after ack.
  task automatic run_op(input string tag, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input int chg_cycle, input int hold);
    logic [W:0] ref_sum;
    logic [1:0] ref_exc;
    int         ack_cyc;
    int         extra;
    ref_sum = {1'b0, d1} + {1'b0, d2};
    ref_exc = {chg_cycle != 0, d1[W-1]};
    ack_cyc = -1;
    extra   = 0;
    @(negedge CLK);
    Adder_datain1 = d1;
    Adder_datain2 = d2;
    Adder_valid   = 1'b1;
    for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
      @(negedge CLK);
      if (Adder_ack) ack_cyc = k;
      else if (k == chg_cycle) begin
        if (k[0]) Adder_datain2 = d2 ^ W'(1 + $urandom_range(0, 1000));
        else      Adder_datain1 = d1 ^ W'(1 << $urandom_range(0, W - 2));
      end
    end
    chk({tag, " ack_latency"}, ack_cyc, LAT);
    chk({tag, " dataout"}, 32'(Adder_dataout), 32'(ref_sum[W-1:0]));
    chk({tag, " carryout"}, 32'(Adder_carryout), 32'(ref_sum[W]));
    chk({tag, " exc"}, 32'(Adder_Exc), 32'(ref_exc));
    for (int j = 0; j < hold; j++) begin
      @(negedge CLK);
      if (Adder_ack) extra++;
    end
    Adder_valid = 1'b0;
    @(negedge CLK);
    if (Adder_ack) extra++;
    chk({tag, " extra_acks"}, extra, 0);
    last_sum   = ref_sum[W-1:0];
    last_carry = ref_sum[W];
    last_exc   = ref_exc;
  endtask

  initial begin
    int acks;
    RSTn          = 1'b0;
    Adder_valid   = 1'b0;
    Adder_datain1 = '0;
    Adder_datain2 = '0;
    repeat (2) @(negedge CLK);
    chk("reset dataout", 32'(Adder_dataout), 0);
    chk("reset carry", 32'(Adder_carryout), 0);
    chk("reset exc", 32'(Adder_Exc), 0);
    chk("reset ack", 32'(Adder_ack), 0);
    RSTn = 1'b1;

    run_op("same_sign", 25'h0800000, 25'h0800000, 0, 0);
    chk("same_sign sum const", 32'(Adder_dataout), 32'h1000000);
    run_op("subtract", 25'h0C00000, 25'h1C00000, 0, 1);
    chk("subtract sum const", 32'(Adder_dataout), 32'h0800000);
    run_op("all_ones", 25'h0FFFFFF, 25'h1FFFFFF, 0, 0);
    chk("all_ones sum const", 32'(Adder_dataout), 32'h0FFFFFE);
    run_op("proto_d2", 25'h0123456, 25'h0654321, 3, 0);
    run_op("op1_neg", 25'h1000001, 25'h0000001, 0, 0);
    run_op("hold3", 25'h0ABCDEF, 25'h1111111, 0, 3);
    run_op("back2back", 25'h0000001, 25'h1FFFFFF, 0, 0);

    // abort: valid dropped in cycle 3 -> no ack, outputs keep prior values
    @(negedge CLK);
    Adder_datain1 = 25'h0555555;
    Adder_datain2 = 25'h0AAAAAA;
    Adder_valid   = 1'b1;
    repeat (3) @(negedge CLK);
    Adder_valid = 1'b0;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (Adder_ack) acks++;
    end
    chk("abort acks", acks, 0);
    chk("abort hold dataout", 32'(Adder_dataout), 32'(last_sum));
    chk("abort hold carry", 32'(Adder_carryout), 32'(last_carry));
    chk("abort hold exc", 32'(Adder_Exc), 32'(last_exc));
    run_op("after_abort", 25'h0555555, 25'h0AAAAAA, 0, 0);

    // reset in cycle 4 of an operation
    run_op("pre_reset", 25'h1000001, 25'h0000002, 2, 0);
    @(negedge CLK);
    Adder_datain1 = 25'h0777777;
    Adder_datain2 = 25'h0111111;
    Adder_valid   = 1'b1;
    repeat (4) @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    chk("midreset dataout", 32'(Adder_dataout), 0);
    chk("midreset carry", 32'(Adder_carryout), 0);
    chk("midreset exc", 32'(Adder_Exc), 0);
    chk("midreset ack", 32'(Adder_ack), 0);
    RSTn        = 1'b1;
    Adder_valid = 1'b0;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (Adder_ack) acks++;
    end
    chk("midreset acks", acks, 0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] r1, r2;
      r1 = W'($urandom);
      r2 = W'($urandom);
      if ($urandom_range(0, 3) != 0) r1[W-1] = 1'b0;
      run_op("random", r1, r2, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
